// File: rtl/cla_nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_nibble_seq_pkg;

  // Width of one carry-lookahead slice; operands are processed this many bits per cycle.
  localparam int SLICE_W = 4;

  // Default number of slices per operand (16-bit add).
  localparam int DEFAULT_NIBBLES = 4;

  // Sequencer states: waiting for operands, adding slices, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the slice index counter; at least one bit even for a single slice.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla_nibble_seq_cla4.sv
// Combinational 4-bit carry-lookahead slice; every carry is computed directly
// from generate/propagate terms rather than rippling through the slice.
module cla4
  import cla_nibble_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               c_in,
  output logic [SLICE_W-1:0] z,
  output logic               c_out
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // Lookahead carry equations, each flattened to two logic levels.
  always_comb begin
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
  end

  assign z     = p ^ c[SLICE_W-1:0];
  assign c_out = c[SLICE_W];

endmodule

// File: rtl/cla_nibble_seq.sv
// Sequential adder: one 4-bit CLA slice is reused once per cycle, with the
// inter-slice carry held in a register, so a W-bit add takes NIBBLES cycles.
module cla_nibble_seq
  import cla_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                       cout,
  output logic                       ovf,
  output logic                       busy
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_x;
  logic [SLICE_W-1:0] slice_y;
  logic [SLICE_W-1:0] slice_z;
  logic               slice_c;

  assign slice_x = a_q[SLICE_W*idx_q +: SLICE_W];
  assign slice_y = b_q[SLICE_W*idx_q +: SLICE_W];

  cla4 u_cla4 (
    .x     (slice_x),
    .y     (slice_y),
    .c_in  (carry_q),
    .z     (slice_z),
    .c_out (slice_c)
  );

  // Next-state logic: operand capture, one slice per RUN cycle, result hold.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = slice_z;
        carry_d = slice_c;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          cout_d  = slice_c;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_z[SLICE_W-1] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset also aborts any in-flight add.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (res) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake is gated by reset so nothing is offered as accepted while res is high.
  assign in_ready  = (state_q == IDLE) && !res;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/cla_nibble_seq.md
CLA_NIBBLE_SEQ -- requirements
Module: cla_nibble_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices per operand; W = 4*NIBBLES.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port res  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  in  1  operand set offered.
REQ-005 SHALL have port in_ready  out  1  block accepts operands this cycle.
REQ-006 SHALL have port a  in  W  operand A.
REQ-007 SHALL have port b  in  W  operand B.
REQ-008 SHALL have port cin  in  1  carry into nibble 0.
REQ-009 SHALL have port out_valid  out  1  result available.
REQ-010 SHALL have port out_ready  in  1  consumer takes result.
REQ-011 SHALL have port sum  out  W  a+b+cin modulo 2^W.
REQ-012 SHALL have port cout  out  1  carry out of nibble NIBBLES-1.
REQ-013 SHALL have port ovf  out  1  two's-complement overflow of the W-bit add.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 IDLE: on in_valid&&in_ready SHALL latch a, b, cin into operand registers, clear nibble index and carry register to cin, go RUN.
REQ-017 RUN: each cycle SHALL add operand nibble[idx] of A and B plus carry register in one 4-bit CLA slice, write result into sum[4*idx+3:4*idx], load slice carry-out into carry register, increment idx.
REQ-018 RUN: on the edge processing idx==NIBBLES-1 SHALL load cout from slice carry-out, load ovf = (A[W-1]==B[W-1]) && (slice sum MSB != A[W-1]), go DONE.
REQ-019 Latency SHALL be exactly NIBBLES rising edges from the accepting edge to out_valid high; throughput one transaction per NIBBLES+2 cycles minimum.
REQ-020 DONE: sum, cout, ovf SHALL hold stable while out_valid && !out_ready.
REQ-021 DONE: on out_ready SHALL go IDLE; in_ready SHALL not be asserted in the same cycle as out_valid.
REQ-022 a, b, cin, in_valid changes during RUN/DONE SHALL have no effect on the in-flight result.
REQ-023 out_ready in IDLE or RUN SHALL have no effect.
REQ-024 Carry SHALL ripple across nibbles via the carry register only; full-width wrap (e.g. all-ones + cin=1) SHALL give sum 0, cout 1.
REQ-025 sum SHALL be considered meaningful only while out_valid is high; partial values during RUN are not contractual.

Reset
REQ-026 While res is high at a rising edge: state<=IDLE, idx<=0, carry register<=0, sum<=0, cout<=0, ovf<=0, out_valid=0, busy=0.
REQ-027 in_valid SHALL be ignored in any cycle res is high; in_ready SHALL be low while res is high and high the first cycle after res falls.
REQ-028 res asserted in RUN or DONE SHALL abort the transaction; no out_valid for it SHALL ever appear.

Structure
REQ-029 Shared package SHALL hold the state enumeration (IDLE/RUN/DONE), slice width constant 4 and default NIBBLES.
REQ-030 SHALL instantiate exactly one sub-module, cla4: combinational 4-bit carry-lookahead slice (x[4], y[4], c_in -> z[4], c_out), reused every RUN cycle.
REQ-031 Index counter width SHALL be ceil(log2(NIBBLES)), minimum 1 bit.

Verification (NIBBLES=4)
REQ-032 a=0x1234, b=0x4321, cin=0 -> out_valid 4 edges after accept; sum=0x5555, cout=0, ovf=0.
REQ-033 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (carry through all nibbles).
REQ-034 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-035 out_ready low for 5 cycles after out_valid, in_valid held high with new operands -> sum/cout/ovf stable, in_ready=0, no accept until one cycle after out_ready handshake.
REQ-036 res pulsed high one cycle on the 2nd RUN cycle -> next cycle state IDLE, sum=0, out_valid=0, busy=0, in_ready=1; no out_valid follows.
REQ-037 operands changed every cycle during RUN after accepting a=0x0F0F, b=0x00F1 -> sum=0x1000, cout=0 unaffected.
